// File: rtl/vector_element_sequencer_pkg.sv
// Shared types for the vector element sequencer: element-index width,
// sequencer state encoding and the effective-step helper.
package vector_element_sequencer_pkg;

  localparam int VL_WIDTH = 8;

  typedef logic [VL_WIDTH-1:0] vl_t;
  // One extra bit so idx + step can never wrap when compared against vl.
  typedef logic [VL_WIDTH:0]   vl_ext_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic vl_ext_t eff_step(input int unsigned lanes, input logic widen);
    int unsigned s;
    s = widen ? (lanes / 2) : lanes;
    return vl_ext_t'(s);
  endfunction

endpackage

// File: rtl/vector_element_sequencer_if.sv
// Decode-side and execute-side signals of the vector element sequencer,
// grouped into one interface; the sequencer uses the slave view.
interface vector_element_sequencer_if #(
  parameter int NUM_LANES = 2
);
  import vector_element_sequencer_pkg::*;

  logic                 de_valid;
  logic                 de_ready;
  vl_t                  de_vl;
  vl_t                  de_vstart;
  logic                 de_vd_widen;
  logic                 de_vs2_widen;
  logic                 stall;
  logic                 flush;
  logic                 ex_valid;
  vl_t                  ex_elem_idx;
  logic [NUM_LANES-1:0] ex_lane_mask;
  logic                 ex_first;
  logic                 ex_last;
  logic                 done;
  logic                 busy;

  modport slave (
    input  de_valid, de_vl, de_vstart, de_vd_widen, de_vs2_widen, stall, flush,
    output de_ready, ex_valid, ex_elem_idx, ex_lane_mask, ex_first, ex_last,
           done, busy
  );

  modport master (
    output de_valid, de_vl, de_vstart, de_vd_widen, de_vs2_widen, stall, flush,
    input  de_ready, ex_valid, ex_elem_idx, ex_lane_mask, ex_first, ex_last,
           done, busy
  );

endinterface

// File: rtl/vector_lane_mask_gen.sv
// Combinational lane-mask and last-group generator for one element group
// starting at idx_i, given the instruction vl and the effective step.
module vector_lane_mask_gen
  import vector_element_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  vl_t                  idx_i,
  input  vl_t                  vl_i,
  input  vl_ext_t              step_i,
  output logic [NUM_LANES-1:0] mask_o,
  output logic                 last_o
);

  vl_ext_t idx_ext;
  vl_ext_t vl_ext;

  assign idx_ext = {1'b0, idx_i};
  assign vl_ext  = {1'b0, vl_i};

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      mask_o[i] = (vl_ext_t'(i) < step_i) && ((idx_ext + vl_ext_t'(i)) < vl_ext);
    end
    last_o = (idx_ext + step_i) >= vl_ext;
  end

endmodule

// File: rtl/vector_element_sequencer.sv
// Walks the element index of one decoded vector instruction from vstart to
// vl-1, issuing one registered element group per cycle to the execute lanes.
module vector_element_sequencer
  import vector_element_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  vector_element_sequencer_if.slave   bus
);

  localparam vl_ext_t FULL_STEP = eff_step(NUM_LANES, 1'b0);
  localparam vl_ext_t HALF_STEP = eff_step(NUM_LANES, 1'b1);

  seq_state_t           state_q, state_d;
  vl_t                  idx_q, idx_d;
  vl_t                  vl_q, vl_d;
  vl_ext_t              step_q, step_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic [NUM_LANES-1:0] gen_mask;
  logic                 gen_last;
  logic                 ready;
  logic                 accept;
  logic                 load;

  // Ready while idle, or on the unstalled final group so the next
  // instruction can follow without a bubble.
  assign ready  = !bus.flush && ((state_q == IDLE) || (!bus.stall && last_q));
  assign accept = bus.de_valid && ready;
  assign load   = accept && (bus.de_vstart < bus.de_vl);

  // NOTE: every variable gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vl_d    = vl_q;
    step_d  = step_q;
    first_d = first_q;
    done_d  = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = RUN;
      idx_d   = bus.de_vstart;
      vl_d    = bus.de_vl;
      step_d  = (bus.de_vd_widen || bus.de_vs2_widen) ? HALF_STEP : FULL_STEP;
      first_d = 1'b1;
      done_d  = (state_q == RUN);
    end else if (accept) begin
      // Zero-length instruction, or one arriving as the previous one retires.
      state_d = IDLE;
      done_d  = 1'b1;
    end else if ((state_q == RUN) && !bus.stall) begin
      if (last_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + vl_t'(step_q);
        first_d = 1'b0;
      end
    end

    if (state_d != RUN) begin
      first_d = 1'b0;
    end
  end

  vector_lane_mask_gen #(
    .NUM_LANES (NUM_LANES)
  ) u_mask_gen (
    .idx_i  (idx_d),
    .vl_i   (vl_d),
    .step_i (step_d),
    .mask_o (gen_mask),
    .last_o (gen_last)
  );

  assign mask_d = (state_d == RUN) ? gen_mask : '0;
  assign last_d = (state_d == RUN) && gen_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vl_q    <= '0;
      step_q  <= '0;
      mask_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      step_q  <= step_d;
      mask_q  <= mask_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.de_ready     = ready;
  assign bus.ex_valid     = (state_q == RUN);
  assign bus.ex_elem_idx  = idx_q;
  assign bus.ex_lane_mask = mask_q;
  assign bus.ex_first     = first_q;
  assign bus.ex_last      = last_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q == RUN);

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Directed self-checking bench for vector_element_sequencer (NUM_LANES = 2).
module tb_vector_element_sequencer;
  import vector_element_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vector_element_sequencer_if #(.NUM_LANES(2)) bus ();

  vector_element_sequencer #(
    .NUM_LANES (2)
  ) u_dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input int idx,
                            input logic [1:0] m, input logic f, input logic l,
                            input logic d);
    check({tag, ".valid"}, 32'(bus.ex_valid), 32'(v));
    check({tag, ".busy"},  32'(bus.busy), 32'(v));
    check({tag, ".idx"},   32'(bus.ex_elem_idx), 32'(idx));
    check({tag, ".mask"},  32'(bus.ex_lane_mask), 32'(m));
    check({tag, ".first"}, 32'(bus.ex_first), 32'(f));
    check({tag, ".last"},  32'(bus.ex_last), 32'(l));
    check({tag, ".done"},  32'(bus.done), 32'(d));
  endtask

  task automatic present(input int vl, input int vstart, input logic vdw, input logic vs2w);
    bus.de_valid     = 1'b1;
    bus.de_vl        = vl_t'(vl);
    bus.de_vstart    = vl_t'(vstart);
    bus.de_vd_widen  = vdw;
    bus.de_vs2_widen = vs2w;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.de_valid     = 1'b0;
    bus.de_vl        = '0;
    bus.de_vstart    = '0;
    bus.de_vd_widen  = 1'b0;
    bus.de_vs2_widen = 1'b0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;

    @(negedge clk);
    expect_out("reset", 1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic run: vl=5, vstart=0 -> idx 0, 2, 4; masks 11, 11, 01
    present(5, 0, 1'b0, 1'b0);
    #1 check("basic.ready_idle", 32'(bus.de_ready), 32'd1);
    tick();
    bus.de_valid = 1'b0;
    expect_out("basic.g0", 1'b1, 0, 2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("basic.g1", 1'b1, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    #1 check("basic.ready_mid", 32'(bus.de_ready), 32'd0);
    tick();
    expect_out("basic.g2", 1'b1, 4, 2'b01, 1'b0, 1'b1, 1'b0);
    #1 check("basic.ready_last", 32'(bus.de_ready), 32'd1);
    tick();
    expect_out("basic.done", 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("basic.idle", 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b0);

    // Widen with vstart: vl=4, vstart=1, vd_widen -> idx 1, 2, 3, mask 01
    present(4, 1, 1'b1, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    expect_out("widen.g0", 1'b1, 1, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("widen.g1", 1'b1, 2, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("widen.g2", 1'b1, 3, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("widen.done", 1'b0, 3, 2'b00, 1'b0, 1'b0, 1'b1);

    // vs2 widening alone also halves the step: vl=2 -> idx 0, 1
    present(2, 0, 1'b0, 1'b1);
    tick();
    bus.de_valid = 1'b0;
    expect_out("vs2w.g0", 1'b1, 0, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("vs2w.g1", 1'b1, 1, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("vs2w.done", 1'b0, 1, 2'b00, 1'b0, 1'b0, 1'b1);

    // Stall hold: vl=6, stall three cycles while idx 2 is presented
    present(6, 0, 1'b0, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    expect_out("stall.g0", 1'b1, 0, 2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      expect_out($sformatf("stall.hold%0d", c), 1'b1, 2, 2'b11, 1'b0, 1'b0, 1'b0);
      bus.stall = (c < 3);
      #1 check($sformatf("stall.ready%0d", c), 32'(bus.de_ready), 32'd0);
      tick();
    end
    expect_out("stall.g2", 1'b1, 4, 2'b11, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("stall.done", 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b1);

    // Back-to-back: A (vl=2) then B (vl=4) offered during A's final group
    present(2, 0, 1'b0, 1'b0);
    tick();
    expect_out("b2b.a0", 1'b1, 0, 2'b11, 1'b1, 1'b1, 1'b0);
    present(4, 0, 1'b0, 1'b0);
    #1 check("b2b.ready", 32'(bus.de_ready), 32'd1);
    tick();
    bus.de_valid = 1'b0;
    expect_out("b2b.b0", 1'b1, 0, 2'b11, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("b2b.b1", 1'b1, 2, 2'b11, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("b2b.done", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();

    // Zero-length: vstart=7, vl=7, then vl=0 with vstart=0
    present(7, 7, 1'b0, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    expect_out("zl.done", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("zl.after", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    present(0, 0, 1'b0, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    expect_out("zl0.done", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();

    // Flush with de_valid and stall high during RUN idx 2 (vl=8)
    present(8, 0, 1'b0, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    tick();
    expect_out("flush.g1", 1'b1, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    present(3, 0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    #1 check("flush.ready", 32'(bus.de_ready), 32'd0);
    tick();
    bus.de_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    expect_out("flush.idle", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("flush.noacc", 1'b0, 2, 2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run: no done afterwards
    present(8, 0, 1'b0, 1'b0);
    tick();
    bus.de_valid = 1'b0;
    tick();
    expect_out("rst.g1", 1'b1, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("rst.async", 1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    expect_out("rst.after", 1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst.nodone", 32'(bus.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_element_sequencer.md
Name: vector_element_sequencer

Overview:
- Sits directly downstream of the vector decode/control unit and upstream of the vector execute lanes.
- Accepts one decoded vector instruction per handshake, latches vl/vstart and the widening flags, then walks the element index from vstart to vl-1.
- Issues one element group per cycle to execute, with a per-lane active mask.
- Honours execute-side stall and pipeline flush; supports zero-bubble back-to-back instructions.

Parameters:
NUM_LANES, 2, element lanes issued per cycle (power of two, >=2)
VL_WIDTH, 8, width of vl/vstart/element index (covers VLMAX=128 at e8, LMUL=8)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
de_valid  input  1  decode presents a vector instruction
de_ready  output  1  sequencer can accept this cycle
de_vl  input  VL_WIDTH  vl for the instruction
de_vstart  input  VL_WIDTH  starting element index
de_vd_widen  input  1  widening destination
de_vs2_widen  input  1  widening vs2 source
stall  input  1  execute backpressure; hold issue
flush  input  1  squash in-flight sequence
ex_valid  output  1  element group valid to execute
ex_elem_idx  output  VL_WIDTH  index of lane 0 element
ex_lane_mask  output  NUM_LANES  lane i active iff ex_elem_idx+i < vl
ex_first  output  1  first group of the instruction
ex_last  output  1  final group of the instruction
done  output  1  one-cycle pulse when the final group leaves (not stalled)
busy  output  1  state != IDLE

Behaviour:
- Reset (nRST low, async): state=IDLE; ex_valid, ex_first, ex_last, done, busy = 0; ex_elem_idx = 0; ex_lane_mask = 0.
- Effective step: STEP = NUM_LANES, or NUM_LANES/2 if the latched vd_widen or vs2_widen is set. Lanes at or above STEP are always masked off.
- FSM states: IDLE, RUN.
- IDLE:
  - de_ready = !flush.
  - On accept with de_vstart < de_vl: latch vl, vstart and widen flags; go to RUN.
  - On accept with de_vstart >= de_vl: zero-length instruction. No ex_valid is issued; done pulses the next cycle; stay IDLE.
- RUN:
  - ex_valid = 1. All outputs are registered and the first group appears one cycle after accept.
  - ex_elem_idx starts at vstart; ex_first = 1 only on that group.
  - lane_mask[i] = (i < STEP) && (idx + i < vl).
  - ex_last = (idx + STEP >= vl). The comparison uses VL_WIDTH+1 bits so it cannot wrap.
  - stall=1: every output and the index hold exactly; de_ready = 0.
  - stall=0 and !ex_last: idx += STEP.
  - stall=0 and ex_last: done is asserted the next cycle, and de_ready = !flush in this same cycle.
    - If the next instruction is accepted: reload and stay in RUN (zero bubble).
    - Otherwise: go to IDLE.
- flush (any state): next cycle state=IDLE, ex_valid=0, done=0, and no accept occurs that cycle. Flush has priority over stall, over accept and over completion.
- Idle outputs: in IDLE, ex_valid=0, ex_lane_mask=0, and ex_elem_idx holds its last value.
- Reset mid-RUN: immediate return to reset values. No done is generated.
- vl=0 with vstart=0 is a zero-length instruction.
- Widen with NUM_LANES=2 gives STEP=1, so lane 1 is never active.

Decomposition:
- Shared vector types package:
  - seq_state_t enum {IDLE, RUN}.
  - VL_WIDTH as a package constant, reused by the decode interface and execute.
- Sub-module vector_lane_mask_gen (combinational): idx, vl, step → lane mask and last flag. It is instantiated once and unit-testable in isolation.
- The top level holds the FSM, the latches and the registered output stage.

Test Plan:
- Basic run: NUM_LANES=2, vl=5, vstart=0, no widen → groups idx 0, 2, 4 with masks 11, 11, 01; first on idx 0; last on idx 4; done one cycle after; 3 ex_valid cycles total.
- Widen plus vstart: vl=4, vstart=1, vd_widen=1 → idx 1, 2, 3, mask 01 each; last on idx 3.
- Stall hold: vl=6, assert stall for 3 cycles on idx 2 → idx 2 and mask 11 held stable for 4 cycles, then idx 4 with last; de_ready=0 throughout the stall.
- Back-to-back: instruction A (vl=2) then instruction B (vl=4) presented during A's last group → B's idx 0 appears the cycle after A's last with no bubble; done pulses for A.
- Zero-length: vstart=7, vl=7 → no ex_valid; done pulses one cycle after accept; busy stays 0.
- Flush and reset: flush asserted while de_valid and stall are high during RUN idx 2 (vl=8) → next cycle IDLE, ex_valid=0, no done, no accept. Separately, deassert nRST mid-RUN → all outputs go to zero asynchronously.
